// File: rtl/window_addr_gen_pkg.sv
// Shared types and constants for the sliding-window address generator.
package window_addr_gen_pkg;

   localparam int unsigned DEF_ADDR_W  = 32;
   localparam int unsigned DEF_COORD_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIN
   } state_t;

   // Width of the packed lane bus: one ADDR_W slot per lane.
   function automatic int unsigned lane_bus_w(input int unsigned ports, input int unsigned w);
      return ports * w;
   endfunction

endpackage

// File: rtl/addr_lane_calc.sv
// One output lane: offset = base + row base + column + lane index, zeroed when
// the lane falls past the right edge of the output map.
module addr_lane_calc #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned COORD_W = 16,
   parameter int unsigned LANE    = 0
) (
   input  logic [ADDR_W-1:0]  base_i,
   input  logic [ADDR_W-1:0]  row_base_i,
   input  logic [ADDR_W-1:0]  col_i,
   input  logic [COORD_W-1:0] ox_i,
   input  logic [COORD_W-1:0] out_w_i,
   output logic [ADDR_W-1:0]  offset_o,
   output logic               valid_o
);

   logic [COORD_W:0] lane_x;

   assign lane_x   = {1'b0, ox_i} + (COORD_W+1)'(LANE);
   assign valid_o  = lane_x < {1'b0, out_w_i};
   assign offset_o = valid_o ? (base_i + row_base_i + col_i + ADDR_W'(LANE)) : '0;

endmodule

// File: rtl/window_addr_gen.sv
// Walks kx, ky, ox (step PORT_NUM), oy and emits PORT_NUM masked window offsets
// per beat through a two-stage pipeline (row multiply, lane add/output).
module window_addr_gen
   import window_addr_gen_pkg::*;
#(
   parameter int unsigned PORT_NUM = 4,
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned COORD_W  = DEF_COORD_W,
   parameter int unsigned K        = 5
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   start,
   input  logic [ADDR_W-1:0]                      base_addr,
   input  logic [COORD_W-1:0]                     img_w,
   input  logic [COORD_W-1:0]                     out_w,
   input  logic [COORD_W-1:0]                     out_h,
   output logic [lane_bus_w(PORT_NUM, ADDR_W)-1:0] offset_bus,
   output logic [PORT_NUM-1:0]                    lane_mask,
   output logic                                   valid,
   input  logic                                   ready,
   output logic                                   busy,
   output logic                                   done
);

   localparam int unsigned BUS_W = lane_bus_w(PORT_NUM, ADDR_W);
   localparam int unsigned KW    = (K > 1) ? $clog2(K) : 1;

   state_t               state_q;
   logic                 busy_q, done_q;
   logic [ADDR_W-1:0]    base_q;
   logic [COORD_W-1:0]   img_w_q, out_w_q, out_h_q;
   logic [KW-1:0]        kx_q, kx_d, ky_q, ky_d;
   logic [COORD_W-1:0]   ox_q, ox_d, oy_q, oy_d;
   logic                 issued_all_q;
   logic                 s1_valid_q, s1_last_q;
   logic [ADDR_W-1:0]    s1_row_q, s1_col_q;
   logic [COORD_W-1:0]   s1_ox_q;
   logic                 out_valid_q, out_last_q;
   logic [BUS_W-1:0]     out_off_q;
   logic [PORT_NUM-1:0]  out_mask_q;

   logic                 accept, go, en, issue;
   logic                 kx_last, ky_last, ox_last, oy_last, final_beat;
   logic [COORD_W-1:0]   cur_img_w, cur_out_w, cur_out_h;
   logic [BUS_W-1:0]     lane_off;
   logic [PORT_NUM-1:0]  lane_vld;

   // Beat 0 issues on the start edge itself from the live inputs, so the
   // counters sit at zero in IDLE and config muxes bypass the sampled copies.
   assign accept    = (state_q == IDLE) && start;
   assign go        = accept && (out_w != '0) && (out_h != '0);
   assign en        = !out_valid_q || ready;
   assign issue     = go || ((state_q == RUN) && !issued_all_q);
   assign cur_img_w = (state_q == IDLE) ? img_w : img_w_q;
   assign cur_out_w = (state_q == IDLE) ? out_w : out_w_q;
   assign cur_out_h = (state_q == IDLE) ? out_h : out_h_q;

   assign kx_last    = (kx_q == KW'(K - 1));
   assign ky_last    = (ky_q == KW'(K - 1));
   assign ox_last    = ({1'b0, ox_q} + (COORD_W+1)'(PORT_NUM)) >= {1'b0, cur_out_w};
   assign oy_last    = (oy_q == cur_out_h - COORD_W'(1));
   assign final_beat = kx_last && ky_last && ox_last && oy_last;

   always_comb begin
      kx_d = kx_q;
      ky_d = ky_q;
      ox_d = ox_q;
      oy_d = oy_q;
      if (issue && en) begin
         if (!kx_last) begin
            kx_d = kx_q + KW'(1);
         end else begin
            kx_d = '0;
            if (!ky_last) begin
               ky_d = ky_q + KW'(1);
            end else begin
               ky_d = '0;
               if (!ox_last) begin
                  ox_d = ox_q + COORD_W'(PORT_NUM);
               end else begin
                  ox_d = '0;
                  oy_d = oy_last ? '0 : oy_q + COORD_W'(1);
               end
            end
         end
      end
   end

   for (genvar p = 0; p < PORT_NUM; p++) begin : g_lane
      addr_lane_calc #(
         .ADDR_W (ADDR_W),
         .COORD_W(COORD_W),
         .LANE   (p)
      ) u_lane (
         .base_i    (base_q),
         .row_base_i(s1_row_q),
         .col_i     (s1_col_q),
         .ox_i      (s1_ox_q),
         .out_w_i   (out_w_q),
         .offset_o  (lane_off[p*ADDR_W +: ADDR_W]),
         .valid_o   (lane_vld[p])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         base_q       <= '0;
         img_w_q      <= '0;
         out_w_q      <= '0;
         out_h_q      <= '0;
         kx_q         <= '0;
         ky_q         <= '0;
         ox_q         <= '0;
         oy_q         <= '0;
         issued_all_q <= 1'b0;
         s1_valid_q   <= 1'b0;
         s1_last_q    <= 1'b0;
         s1_row_q     <= '0;
         s1_col_q     <= '0;
         s1_ox_q      <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         out_off_q    <= '0;
         out_mask_q   <= '0;
      end else begin
         kx_q <= kx_d;
         ky_q <= ky_d;
         ox_q <= ox_d;
         oy_q <= oy_d;
         if (accept) begin
            base_q  <= base_addr;
            img_w_q <= img_w;
            out_w_q <= out_w;
            out_h_q <= out_h;
         end
         if (issue && en && final_beat) begin
            issued_all_q <= 1'b1;
         end else if (accept) begin
            issued_all_q <= 1'b0;
         end
         if (en) begin
            s1_valid_q  <= issue;
            s1_last_q   <= issue && final_beat;
            s1_row_q    <= (ADDR_W'(oy_q) + ADDR_W'(ky_q)) * ADDR_W'(cur_img_w);
            s1_col_q    <= ADDR_W'(ox_q) + ADDR_W'(kx_q);
            s1_ox_q     <= ox_q;
            out_valid_q <= s1_valid_q;
            out_last_q  <= s1_valid_q && s1_last_q;
            out_off_q   <= s1_valid_q ? lane_off : '0;
            out_mask_q  <= s1_valid_q ? lane_vld : '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (go) begin
                  state_q <= RUN;
                  busy_q  <= 1'b1;
               end else if (accept) begin
                  state_q <= FIN;
                  done_q  <= 1'b1;
               end
            end
            RUN: begin
               if (out_valid_q && ready && out_last_q) begin
                  state_q <= FIN;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            FIN:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign offset_bus = out_off_q;
   assign lane_mask  = out_mask_q;
   assign valid      = out_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: doc/window_addr_gen.md
WINDOW_ADDR_GEN -- requirements
Module: window_addr_gen

Interface
REQ-001 Parameter PORT_NUM, default 4, number of parallel offset lanes per beat (1..26).
REQ-002 Parameter ADDR_W, default 32, width of every offset lane and of base_addr.
REQ-003 Parameter COORD_W, default 16, width of image and output dimension inputs.
REQ-004 Parameter K, default 5, square kernel size (1..11).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  launch pulse; samples base_addr, img_w, out_w, out_h.
REQ-008 base_addr  in  ADDR_W  feature-map base offset.
REQ-009 img_w  in  COORD_W  input image row pitch in elements.
REQ-010 out_w, out_h  in  COORD_W each  output map width, height.
REQ-011 offset_bus  out  PORT_NUM*ADDR_W  packed lane offsets, lane p at bits [p*ADDR_W +: ADDR_W].
REQ-012 lane_mask  out  PORT_NUM  bit p = lane p carries a real address.
REQ-013 valid  out  1 / ready  in  1  beat handshake; beat transfers when valid&&ready.
REQ-014 busy  out  1  high from the cycle after accepted start until done.
REQ-015 done  out  1  one-cycle completion pulse.

Function
REQ-016 States IDLE, RUN, FIN; IDLE->RUN on start (nonzero dims), RUN->FIN on final beat transfer, FIN->IDLE unconditionally after one cycle.
REQ-017 Loop order, innermost first: kx 0..K-1, ky 0..K-1, ox 0..out_w-1 step PORT_NUM, oy 0..out_h-1.
REQ-018 Lane p offset = base_addr + (oy+ky)*img_w + ox + p + kx, truncated modulo 2^ADDR_W.
REQ-019 Lane p valid iff ox+p < out_w; masked lanes drive offset 0.
REQ-020 Total beats = ceil(out_w/PORT_NUM) * out_h * K * K.
REQ-021 First valid asserted exactly 2 cycles after the start cycle (one registered multiply stage, one output register).
REQ-022 While valid&&!ready, offset_bus, lane_mask, valid hold stable; counters frozen.
REQ-023 With ready held high, one beat per cycle, no bubbles, including across ox/oy wrap.
REQ-024 done pulses the cycle after the final beat transfers; busy falls in the same cycle.
REQ-025 start while busy is ignored; configuration inputs are don't-care after sampling.
REQ-026 start with out_w==0 or out_h==0: no beats, done pulses 1 cycle after start, busy stays low.

Reset
REQ-027 rst high for one cycle forces state IDLE, all counters 0, valid=0, busy=0, done=0, offset_bus=0, lane_mask=0.
REQ-028 rst mid-run aborts the sweep; no further beats and no done pulse; next start begins from ox=oy=kx=ky=0.
REQ-029 rst takes priority over start in the same cycle.

Structure
REQ-030 Shared package holds the state enum, default ADDR_W/COORD_W constants and the lane pack/unpack width function.
REQ-031 One sub-module, addr_lane_calc, computes the masked lane offset from row base, column and lane index; instantiated PORT_NUM times by generate.
REQ-032 Row base (oy+ky)*img_w computed once per beat and shared by all lanes.

Verification
REQ-033 PORT_NUM=4, K=3, base=100, img_w=8, out_w=6, out_h=6, ready=1 -> first beat offsets 100,101,102,103 mask 1111 at start+2; 108 beats; done once.
REQ-034 Same config, beat for ox=4, oy=0, ky=1, kx=2 -> offsets 114,115,0,0, mask 0011.
REQ-035 ready low 5 cycles mid-run -> payload bit-identical through stall; total beat count still 108.
REQ-036 rst asserted on beat 40 -> valid=0 next cycle, no done; restart yields first beat 100..103 again.
REQ-037 start with out_h=0 -> zero beats, done at start+1; start pulse during busy -> no effect on count.
REQ-038 base=0xFFFFFFFE, img_w=1, out_w=4, out_h=1, K=1 -> offsets FFFFFFFE, FFFFFFFF, 0, 1 mask 1111.
